// File: rtl/wb_load_queue_if.sv
// Request, response and write-back signals of the load write-back unit.
interface wb_load_queue_if #(
    parameter int XLEN = 32
);
    localparam int AW = $clog2(XLEN / 8);

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [AW-1:0]   req_addr_lo;
    logic [4:0]      req_rd;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_err;
    logic            rsp_orphan;

    // Core / memory side: issues loads, returns raw data, consumes write-back.
    modport master (
        output req_valid, req_funct3, req_addr_lo, req_rd, rsp_valid, rsp_data,
        input  req_ready, wb_valid, wb_rd, wb_data, wb_err, rsp_orphan
    );

    // Load unit side.
    modport slave (
        input  req_valid, req_funct3, req_addr_lo, req_rd, rsp_valid, rsp_data,
        output req_ready, wb_valid, wb_rd, wb_data, wb_err, rsp_orphan
    );
endinterface

// File: rtl/wb_load_queue.sv
// Write-back load unit: queues metadata of outstanding loads, aligns and
// extends memory responses in order, and generates the branch bubble.
module wb_load_queue #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    wb_load_queue_if.slave   bus,
    input  logic             flush,
    input  logic             branch_in,
    input  logic             stall_read,
    output logic             wb_stall
);
    localparam int AW = $clog2(XLEN / 8);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]    funct3;
        logic [AW-1:0] addr_lo;
        logic [4:0]    rd;
    } entry_t;

    entry_t          queue [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    entry_t          head;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;
    logic [2:0]      size_mask;
    logic [2:0]      addr3;
    logic            illegal;
    logic            misaligned;
    logic            err;

    logic [3:0]      bubble_cnt;
    logic [3:0]      bubble_next;

    assign full          = (count == (PW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign bus.req_ready = !full;
    assign push          = bus.req_valid && !full && !flush;
    assign pop           = bus.rsp_valid && !empty && !flush;
    assign head          = queue[rd_ptr];

    // Queue storage: written on push only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[wr_ptr] <= '{funct3: bus.req_funct3, addr_lo: bus.req_addr_lo, rd: bus.req_rd};
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Align the response to the head entry's byte offset and extend it.
    always_comb begin
        shifted   = bus.rsp_data >> {head.addr_lo, 3'b000};
        addr3     = 3'(head.addr_lo);
        ext       = '0;
        size_mask = 3'b000;
        illegal   = 1'b0;
        case (head.funct3)
            3'b000: ext = XLEN'($signed(shifted[7:0]));
            3'b001: begin ext = XLEN'($signed(shifted[15:0])); size_mask = 3'b001; end
            3'b010: begin ext = XLEN'($signed(shifted[31:0])); size_mask = 3'b011; end
            3'b011: begin ext = shifted; size_mask = 3'b111; illegal = (XLEN == 32); end
            3'b100: ext = XLEN'(shifted[7:0]);
            3'b101: begin ext = XLEN'(shifted[15:0]); size_mask = 3'b001; end
            3'b110: begin ext = XLEN'(shifted[31:0]); size_mask = 3'b011; illegal = (XLEN == 32); end
            default: illegal = 1'b1;
        endcase
        misaligned = (addr3 & size_mask) != 3'b000;
        err        = illegal || misaligned;
    end

    // Registered write-back; data, rd and err hold while no load retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_valid   <= 1'b0;
            bus.wb_rd      <= '0;
            bus.wb_data    <= '0;
            bus.wb_err     <= 1'b0;
            bus.rsp_orphan <= 1'b0;
        end else begin
            bus.wb_valid   <= pop;
            bus.rsp_orphan <= bus.rsp_valid && empty && !flush;
            if (pop) begin
                bus.wb_rd   <= head.rd;
                bus.wb_data <= err ? '0 : ext;
                bus.wb_err  <= err;
            end
        end
    end

    // Next bubble count: branch reloads, otherwise count down unless fetch stalls.
    always_comb begin
        bubble_next = bubble_cnt;
        if (!stall_read) begin
            if (branch_in)               bubble_next = 4'(FLUSH_CYCLES);
            else if (bubble_cnt != '0)   bubble_next = bubble_cnt - 1'b1;
        end
    end

    // Bubble counter and its registered stall flag, kept in step with each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            bubble_cnt <= bubble_next;
            wb_stall   <= (bubble_next != '0);
        end
    end
endmodule

// File: tb/tb_wb_load_queue.sv
// Directed bench for wb_load_queue with one XLEN=32 and one XLEN=64 instance.
module tb_wb_load_queue;
    logic clk = 1'b0;
    logic reset;
    logic flush, branch_in, stall_read;
    logic stall32, stall64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_load_queue_if #(.XLEN(32)) b32 ();
    wb_load_queue_if #(.XLEN(64)) b64 ();

    wb_load_queue #(.XLEN(32), .DEPTH(4), .FLUSH_CYCLES(2)) dut32 (
        .clk(clk), .reset(reset), .bus(b32), .flush(flush),
        .branch_in(branch_in), .stall_read(stall_read), .wb_stall(stall32)
    );

    wb_load_queue #(.XLEN(64), .DEPTH(4), .FLUSH_CYCLES(2)) dut64 (
        .clk(clk), .reset(reset), .bus(b64), .flush(flush),
        .branch_in(branch_in), .stall_read(stall_read), .wb_stall(stall64)
    );

    typedef struct {
        string       name;
        logic        is64;
        logic [2:0]  f3;
        logic [2:0]  addr;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push32(input logic [2:0] f3, input logic [1:0] addr, input logic [4:0] rd);
        b32.req_valid   = 1'b1;
        b32.req_funct3  = f3;
        b32.req_addr_lo = addr;
        b32.req_rd      = rd;
    endtask

    // One load through the queue: push, respond next cycle, check write-back.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.is64) begin
            b64.req_valid   = 1'b1;
            b64.req_funct3  = v.f3;
            b64.req_addr_lo = v.addr;
            b64.req_rd      = v.rd;
        end else begin
            push32(v.f3, v.addr[1:0], v.rd);
        end
        @(negedge clk);
        b32.req_valid = 1'b0;
        b64.req_valid = 1'b0;
        if (v.is64) begin
            b64.rsp_valid = 1'b1;
            b64.rsp_data  = v.data;
        end else begin
            b32.rsp_valid = 1'b1;
            b32.rsp_data  = v.data[31:0];
        end
        @(negedge clk);
        b32.rsp_valid = 1'b0;
        b64.rsp_valid = 1'b0;
        if (v.is64) begin
            chk({v.name, " wb_valid"}, 64'(b64.wb_valid), 64'd1);
            chk({v.name, " wb_rd"},    64'(b64.wb_rd),    64'(v.rd));
            chk({v.name, " wb_data"},  b64.wb_data,       v.exp_data);
            chk({v.name, " wb_err"},   64'(b64.wb_err),   64'(v.exp_err));
        end else begin
            chk({v.name, " wb_valid"}, 64'(b32.wb_valid), 64'd1);
            chk({v.name, " wb_rd"},    64'(b32.wb_rd),    64'(v.rd));
            chk({v.name, " wb_data"},  64'(b32.wb_data),  v.exp_data);
            chk({v.name, " wb_err"},   64'(b32.wb_err),   64'(v.exp_err));
        end
    endtask

    initial begin
        logic [31:0] seq_data [3];
        logic [31:0] seq_exp  [3];

        //          name        64  f3      addr  rd  data                    exp                     err
        vecs[0]  = '{"lb_a3",   0, 3'b000, 3'd3, 5, 64'h80AA_BBCC,           64'hFFFF_FF80,           0};
        vecs[1]  = '{"lhu_a2",  0, 3'b101, 3'd2, 6, 64'h1234_5678,           64'h0000_1234,           0};
        vecs[2]  = '{"lw_a0",   0, 3'b010, 3'd0, 7, 64'hDEAD_BEEF,           64'hDEAD_BEEF,           0};
        vecs[3]  = '{"lbu_a1",  0, 3'b100, 3'd1, 8, 64'h0000_9A00,           64'h0000_009A,           0};
        vecs[4]  = '{"lw_a2",   0, 3'b010, 3'd2, 9, 64'hDEAD_BEEF,           64'h0,                   1};
        vecs[5]  = '{"ld_x32",  0, 3'b011, 3'd0, 10, 64'hDEAD_BEEF,          64'h0,                   1};
        vecs[6]  = '{"lh_a2",   0, 3'b001, 3'd2, 11, 64'h8001_0000,          64'hFFFF_8001,           0};
        vecs[7]  = '{"lh_a1",   0, 3'b001, 3'd1, 12, 64'h8001_0000,          64'h0,                   1};
        vecs[8]  = '{"f3_111",  0, 3'b111, 3'd0, 13, 64'h1111_1111,          64'h0,                   1};
        vecs[9]  = '{"lwu_x32", 0, 3'b110, 3'd0, 14, 64'h1111_1111,          64'h0,                   1};
        vecs[10] = '{"lb_a0",   0, 3'b000, 3'd0, 15, 64'h0000_007F,          64'h0000_007F,           0};
        vecs[11] = '{"ld_a0",   1, 3'b011, 3'd0, 16, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 0};
        vecs[12] = '{"lwu_a4",  1, 3'b110, 3'd4, 17, 64'h8000_0000_0000_0001, 64'h0000_0000_8000_0000, 0};
        vecs[13] = '{"lw64_a4", 1, 3'b010, 3'd4, 18, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000, 0};
        vecs[14] = '{"ld_a4",   1, 3'b011, 3'd4, 19, 64'h8000_0000_0000_0001, 64'h0,                   1};
        vecs[15] = '{"lb64_a7", 1, 3'b000, 3'd7, 20, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FF80, 0};
        vecs[16] = '{"lhu64_a6",1, 3'b101, 3'd6, 21, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 0};

        reset = 1'b1; flush = 1'b0; branch_in = 1'b0; stall_read = 1'b0;
        b32.req_valid = 1'b0; b32.req_funct3 = '0; b32.req_addr_lo = '0; b32.req_rd = '0;
        b32.rsp_valid = 1'b0; b32.rsp_data = '0;
        b64.req_valid = 1'b0; b64.req_funct3 = '0; b64.req_addr_lo = '0; b64.req_rd = '0;
        b64.rsp_valid = 1'b0; b64.rsp_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst wb_valid",   64'(b32.wb_valid),   64'd0);
        chk("rst wb_data",    64'(b32.wb_data),    64'd0);
        chk("rst wb_err",     64'(b32.wb_err),     64'd0);
        chk("rst req_ready",  64'(b32.req_ready),  64'd1);
        chk("rst orphan",     64'(b32.rsp_orphan), 64'd0);
        chk("rst stall",      64'(stall32),        64'd0);
        chk("rst ready64",    64'(b64.req_ready),  64'd1);

        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // Three back-to-back pushes, then three back-to-back responses in order.
        seq_data = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_9A00};
        seq_exp  = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_009A};
        @(negedge clk); push32(3'b101, 2'd2, 5'd1);
        @(negedge clk); push32(3'b010, 2'd0, 5'd2);
        @(negedge clk); push32(3'b100, 2'd1, 5'd3);
        @(negedge clk); b32.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b32.rsp_valid = 1'b1;
            b32.rsp_data  = seq_data[i];
            @(negedge clk);
            chk("b2b wb_valid", 64'(b32.wb_valid), 64'd1);
            chk("b2b wb_rd",    64'(b32.wb_rd),    64'(i + 1));
            chk("b2b wb_data",  64'(b32.wb_data),  64'(seq_exp[i]));
        end
        b32.rsp_valid = 1'b0;
        @(negedge clk);
        chk("b2b idle wb_valid", 64'(b32.wb_valid), 64'd0);
        chk("b2b hold wb_data",  64'(b32.wb_data),  64'h9A);

        // Fill to DEPTH, ignored 5th request, push+pop at count 3, drain.
        for (int i = 0; i < 4; i++) begin
            push32(3'b010, 2'd0, 5'(10 + i));
            @(negedge clk);
        end
        chk("full req_ready", 64'(b32.req_ready), 64'd0);
        push32(3'b010, 2'd0, 5'd9);
        @(negedge clk);
        chk("full hold ready", 64'(b32.req_ready), 64'd0);
        b32.req_valid = 1'b0;
        b32.rsp_valid = 1'b1;
        b32.rsp_data  = 32'hCAFE_0000;
        @(negedge clk);
        chk("full pop rd",    64'(b32.wb_rd),     64'd10);
        chk("count3 ready",   64'(b32.req_ready), 64'd1);
        push32(3'b010, 2'd0, 5'd14);
        @(negedge clk);
        b32.req_valid = 1'b0;
        chk("pushpop rd",     64'(b32.wb_rd),     64'd11);
        chk("pushpop ready",  64'(b32.req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain wb_valid", 64'(b32.wb_valid), 64'd1);
            chk("drain rd",       64'(b32.wb_rd),    64'(12 + i));
        end
        // Queue is now empty: this response is an orphan.
        @(negedge clk);
        chk("orphan pulse",    64'(b32.rsp_orphan), 64'd1);
        chk("orphan wb_valid", 64'(b32.wb_valid),   64'd0);
        b32.rsp_valid = 1'b0;
        @(negedge clk);
        chk("orphan end",      64'(b32.rsp_orphan), 64'd0);

        // Flush with three pending and a same-cycle response.
        for (int i = 0; i < 3; i++) begin
            push32(3'b000, 2'd0, 5'(20 + i));
            @(negedge clk);
        end
        b32.req_valid = 1'b0;
        flush = 1'b1;
        b32.rsp_valid = 1'b1;
        b32.rsp_data  = 32'h0000_0055;
        @(negedge clk);
        flush = 1'b0;
        chk("flush ready",    64'(b32.req_ready),  64'd1);
        chk("flush wb_valid", 64'(b32.wb_valid),   64'd0);
        chk("flush orphan",   64'(b32.rsp_orphan), 64'd0);
        @(negedge clk);
        chk("post flush orphan",   64'(b32.rsp_orphan), 64'd1);
        chk("post flush wb_valid", 64'(b32.wb_valid),   64'd0);
        b32.rsp_valid = 1'b0;

        // Bubble: two cycles for a lone branch.
        @(negedge clk);
        branch_in = 1'b1;
        @(negedge clk);
        branch_in = 1'b0;
        chk("bubble c1", 64'(stall32), 64'd1);
        @(negedge clk);
        chk("bubble c2", 64'(stall32), 64'd1);
        @(negedge clk);
        chk("bubble end", 64'(stall32), 64'd0);

        // Bubble stretched to three cycles by a one-cycle fetch stall.
        branch_in = 1'b1;
        @(negedge clk);
        branch_in = 1'b0;
        chk("sbubble c1", 64'(stall32), 64'd1);
        stall_read = 1'b1;
        @(negedge clk);
        stall_read = 1'b0;
        chk("sbubble c2", 64'(stall32), 64'd1);
        @(negedge clk);
        chk("sbubble c3", 64'(stall32), 64'd1);
        @(negedge clk);
        chk("sbubble end", 64'(stall32), 64'd0);

        // Reload while nonzero restarts the count.
        branch_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        branch_in = 1'b0;
        chk("reload c1", 64'(stall32), 64'd1);
        @(negedge clk);
        chk("reload c2", 64'(stall32), 64'd1);
        @(negedge clk);
        chk("reload end", 64'(stall32), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
